// File: rtl/dmem_if.sv
// dmem_if: data-memory request/response bundle between the M/W stage and memory
interface dmem_if;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [31:0] d;
  logic        ready;
  logic [31:0] q;
  modport master (output req, we, addr, d, input ready, q);
  modport slave  (input req, we, addr, d, output ready, q);
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: issues lw/sw memory requests, stalls M while memory is busy, and registers M into W
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction_M,
  input  logic        valid_M,
  input  logic [31:0] aluResult_M,
  input  logic [31:0] dataB_M,
  input  logic [31:0] pcPlus1_M,
  dmem_if.master      dmem,
  output logic        stall_M,
  output logic [31:0] instruction_W,
  output logic [31:0] aluResult_W,
  output logic [31:0] memData_W,
  output logic [31:0] pcPlus1_W,
  output logic        valid_W,
  output logic        mem_error
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d, alu_q, alu_d, mem_q, mem_d, pc_q, pc_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic        is_lw, is_sw, timeout;
  always_comb begin
    is_lw     = valid_M && instruction_M[31:27] == 5'd8;
    is_sw     = valid_M && instruction_M[31:27] == 5'd7;
    timeout   = state_q == WAIT && cnt_q == 8'(TIMEOUT_CYCLES - 1) && !dmem.ready;
    dmem.req  = !reset && (state_q == WAIT || is_lw || is_sw);
    dmem.we   = is_sw;
    dmem.addr = aluResult_M[11:0];
    dmem.d    = dataB_M;
    // ready wins over a coinciding timeout
    stall_M   = dmem.req && !dmem.ready && !timeout;
    state_d   = stall_M ? WAIT : IDLE;
    cnt_d     = (state_q == WAIT && stall_M) ? cnt_q + 8'd1 : 8'd0;
    instr_d   = (stall_M || !valid_M) ? 32'h0 : instruction_M;
    alu_d     = stall_M ? 32'h0 : aluResult_M;
    pc_d      = stall_M ? 32'h0 : pcPlus1_M;
    valid_d   = !stall_M && valid_M;
    mem_d     = (!stall_M && is_lw) ? (timeout ? 32'h0 : dmem.q) : mem_q;
    err_d     = err_q || timeout;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      alu_q   <= '0;
      mem_q   <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign instruction_W = instr_q;
  assign aluResult_W   = alu_q;
  assign memData_W     = mem_q;
  assign pcPlus1_W     = pc_q;
  assign valid_W       = valid_q;
  assign mem_error     = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized lw/sw/ALU traffic checked every cycle against a transaction-level model
module tb_mem_wb_stage;
  localparam int T = 4;
  logic        clock = 0, reset = 0;
  logic [31:0] instruction_M = 0, aluResult_M = 0, dataB_M = 0, pcPlus1_M = 0;
  logic        valid_M = 0, stall_M, valid_W, mem_error;
  logic [31:0] instruction_W, aluResult_W, memData_W, pcPlus1_W;
  dmem_if dif ();
  mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .instruction_M(instruction_M), .valid_M(valid_M),
    .aluResult_M(aluResult_M), .dataB_M(dataB_M), .pcPlus1_M(pcPlus1_M), .dmem(dif),
    .stall_M(stall_M), .instruction_W(instruction_W), .aluResult_W(aluResult_W),
    .memData_W(memData_W), .pcPlus1_W(pcPlus1_W), .valid_W(valid_W), .mem_error(mem_error));
  always #5 clock = ~clock;
  int passed = 0, total = 0;
  bit chk_en = 0;
  logic        ex_stall = 0, ex_req = 0, ex_we = 0, ew_v = 0, ew_err = 0;
  logic [11:0] ex_addr = 0;
  logic [31:0] ex_d = 0, ew_ins = 0, ew_alu = 0, ew_mem = 0, ew_pc = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
    else passed++;
  endtask
  always @(negedge clock) if (chk_en) begin
    chk("stall_M", stall_M, ex_stall);
    chk("dmem_req", dif.req, ex_req);
    chk("dmem_we", dif.we, ex_we);
    chk("dmem_addr", dif.addr, ex_addr);
    chk("dmem_d", dif.d, ex_d);
    chk("instruction_W", instruction_W, ew_ins);
    chk("aluResult_W", aluResult_W, ew_alu);
    chk("memData_W", memData_W, ew_mem);
    chk("pcPlus1_W", pcPlus1_W, ew_pc);
    chk("valid_W", valid_W, ew_v);
    chk("mem_error", mem_error, ew_err);
  end
  // One instruction held in M; memory answers k cycles after issue (k=0: same cycle).
  // It occupies min(k,T)+1 cycles: min(k,T) bubbles, then the instruction reaches W.
  task automatic run_op(input logic [31:0] ins, input logic v, input logic [31:0] alu, b, pc, q, input int k);
    logic lw, sw, mem;
    int d;
    lw  = v && ins[31:27] == 5'd8;
    sw  = v && ins[31:27] == 5'd7;
    mem = lw || sw;
    d   = mem ? ((k < T ? k : T) + 1) : 1;
    for (int j = 0; j < d; j++) begin
      instruction_M = ins; valid_M = v; aluResult_M = alu; dataB_M = b; pcPlus1_M = pc;
      dif.q = mem ? q : $urandom;
      dif.ready = mem ? (j == k) : 1'($urandom % 2);
      ex_stall = mem && j < d - 1;
      ex_req = mem; ex_we = sw; ex_addr = alu[11:0]; ex_d = b;
      @(posedge clock);
      if (j < d - 1) begin
        ew_ins = 0; ew_alu = 0; ew_pc = 0; ew_v = 0;
      end else begin
        ew_ins = v ? ins : 32'h0; ew_alu = alu; ew_pc = pc; ew_v = v;
        if (lw) ew_mem = (k <= T) ? q : 32'h0;
        if (mem && k > T) ew_err = 1;
      end
      #1;
    end
  endtask
  initial begin
    dif.ready = 0; dif.q = 0;
    instruction_M = {5'd8, 27'h5}; valid_M = 1; aluResult_M = 32'h123;
    #2 reset = 1;
    #1;
    chk("rst_req", dif.req, 0);
    chk("rst_stall", stall_M, 0);
    chk("rst_instW", instruction_W, 0);
    chk("rst_validW", valid_W, 0);
    chk("rst_err", mem_error, 0);
    @(posedge clock); #1 reset = 0;
    chk_en = 1;
    run_op(32'h0000_1234, 1, 32'h5, 32'h9, 32'h1, 0, 0);
    chk("lit_add_alu", aluResult_W, 32'h5);
    chk("lit_add_ins", instruction_W, 32'h0000_1234);
    run_op({5'd8, 27'h42}, 1, 32'h10, 0, 32'h2, 32'hCAFE, 0);
    chk("lit_lw_mem", memData_W, 32'hCAFE);
    chk("lit_lw_valid", valid_W, 1);
    run_op({5'd7, 27'h3}, 1, 32'h20, 32'h77, 32'h3, 0, 3);
    chk("lit_sw_ins", instruction_W, {5'd7, 27'h3});
    run_op({5'd8, 27'h7}, 1, 32'h30, 0, 32'h4, 32'hBEEF, T);
    chk("lit_tie_err", mem_error, 0);
    chk("lit_tie_mem", memData_W, 32'hBEEF);
    run_op({5'd8, 27'h8}, 1, 32'h40, 0, 32'h5, 32'hDEAD, 100);
    chk("lit_to_err", mem_error, 1);
    chk("lit_to_mem", memData_W, 0);
    chk("lit_to_valid", valid_W, 1);
    run_op(32'h0800_0001, 1, 32'h6, 0, 32'h6, 0, 0);
    chk("lit_after_err", mem_error, 1);
    chk("lit_after_alu", aluResult_W, 32'h6);
    for (int i = 0; i < 300; i++) begin
      logic [4:0] op;
      op = ($urandom % 3 == 0) ? 5'($urandom) : (($urandom % 2) ? 5'd7 : 5'd8);
      run_op({op, 27'($urandom)}, ($urandom % 5) != 0, $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 6)));
    end
    chk_en = 0;
    instruction_M = {5'd8, 27'h1}; valid_M = 1; dif.ready = 0;
    @(posedge clock); @(posedge clock); #3 reset = 1;
    #1;
    chk("mid_req", dif.req, 0);
    chk("mid_stall", stall_M, 0);
    chk("mid_instW", instruction_W, 0);
    chk("mid_aluW", aluResult_W, 0);
    chk("mid_memW", memData_W, 0);
    chk("mid_pcW", pcPlus1_W, 0);
    chk("mid_validW", valid_W, 0);
    chk("mid_err", mem_error, 0);
    ew_ins = 0; ew_alu = 0; ew_mem = 0; ew_pc = 0; ew_v = 0; ew_err = 0;
    @(posedge clock); #1 reset = 0;
    chk_en = 1;
    run_op({5'd3, 27'h9}, 1, 32'h0, 0, 32'h21, 0, 0);
    chk("lit_jal_pc", pcPlus1_W, 32'h21);
    @(posedge clock); #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access sequencer and M/W pipeline register. It sits between the memory stage and the writeback decoder. It issues data-memory requests for `lw`/`sw` and holds the pipeline while a multi-cycle memory responds. It then registers the instruction and its result sources so the writeback decoder and writeback mux see them one cycle later.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles for `dmem_ready` before a forced completion; range 1..255.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `instruction_M` in 32: M-stage instruction; opcode is [31:27].
- `valid_M` in 1: M-stage instruction is real, not a bubble.
- `aluResult_M` in 32: ALU result; this is the memory address for `lw`/`sw`.
- `dataB_M` in 32: store data for `sw`.
- `pcPlus1_M` in 32: PC+1 of the M-stage instruction.
- `dmem_ready` in 1: memory completes the current request this cycle.
- `dmem_q` in 32: load data, valid when `dmem_ready` is 1.
- `dmem_req` out 1: request active.
- `dmem_we` out 1: request is a store.
- `dmem_addr` out 12: equals `aluResult_M[11:0]`.
- `dmem_d` out 32: equals `dataB_M`.
- `stall_M` out 1: upstream must hold the M-stage inputs and PC.
- `instruction_W` out 32: registered instruction; feeds the writeback decoder.
- `aluResult_W` out 32: registered ALU result (writeback select 00).
- `memData_W` out 32: registered load data (select 01).
- `pcPlus1_W` out 32: registered PC+1 (select 10; jal).
- `valid_W` out 1: W-stage instruction is real.
- `mem_error` out 1: sticky flag, set on timeout.

## Operation
- A memory op is `valid_M` with opcode 5'd8 (`lw`) or 5'd7 (`sw`). All other opcodes, and any cycle with `valid_M` = 0, never request memory.
- FSM states are IDLE and WAIT.
- **IDLE:**
  - `dmem_req` = 1 combinationally when a memory op is present.
  - `dmem_we` = 1 only for `sw`.
  - If `dmem_ready` is also 1, the op completes this cycle with no stall.
  - Otherwise `stall_M` = 1 and the next state is WAIT, with the counter cleared to 0.
- **WAIT:**
  - `dmem_req` and `stall_M` stay at 1. Address, data and `dmem_we` follow the held M inputs.
  - The counter increments each cycle.
  - On `dmem_ready` = 1: complete and go to IDLE.
  - On counter = `TIMEOUT_CYCLES` − 1 without ready: set `mem_error`, complete with load data 32'h0, and go to IDLE.
  - Ready and timeout in the same cycle: ready wins; `mem_error` is not set.
- **Pipeline register:** on a completing or non-memory cycle (`stall_M` = 0), the posedge captures:
  - `instruction_M`, `aluResult_M`, `pcPlus1_M` and `valid_M`;
  - `memData_W` ← `dmem_q` for a completed `lw`, or 0 on a timed-out `lw`; otherwise `memData_W` holds its value.
- **Bubble:**
  - When `stall_M` = 1, the posedge loads a bubble: `instruction_W` = 32'h0 (nop; writes $r0 only) and `valid_W` = 0. `aluResult_W` and `pcPlus1_W` are loaded with 0.
  - When `valid_M` = 0 and there is no stall, the posedge also loads `instruction_W` = 0.
- **mem_error:** cleared only by reset.

## Timing
- **Reset values:** all registered outputs are 0; state is IDLE; counter is 0; `mem_error` is 0.
  - Combinational outputs during reset: `dmem_req` and `stall_M` are 0 regardless of inputs.
- **Latency:**
  - Non-memory op: 1 cycle M→W.
  - Memory op with ready in k cycles after issue (k = 0 means same cycle): k+1 cycles M→W, with k bubbles inserted ahead of it.
- `stall_M` is a Mealy output. It is 1 in the issue cycle (when ready is absent) and in every WAIT cycle except the completing one.
- **Handshake:** the request is held stable until ready; it is never withdrawn mid-request. Exactly one `dmem_ready` pulse is consumed per request.
- **Back-to-back memory ops:** the second op issues in the cycle after the first completes, with no idle gap.
- **Reset asserted in WAIT:** the request is dropped immediately (async), the FSM returns to IDLE, and the W registers are cleared. A late `dmem_ready` arriving in IDLE with no memory op is ignored.

## Test plan
- **ALU op, no stall:** `add` (opcode 0) with `aluResult_M` = 32'h5 and `valid_M` = 1 → next cycle `instruction_W` = input, `aluResult_W` = 5, `valid_W` = 1, `stall_M` never 1.
- **Zero-wait load:** `lw` with `aluResult_M` = 32'h10 and `dmem_ready` = 1 in the same cycle, `dmem_q` = 32'hCAFE → `dmem_addr` = 12'h010, `dmem_we` = 0, no stall; next cycle `memData_W` = 32'hCAFE, `valid_W` = 1.
- **3-cycle store:** `sw` with `dataB_M` = 32'h77 and ready asserted 3 cycles after issue → `stall_M` high for 3 cycles, `dmem_we` = 1 throughout, W shows 3 bubbles (`instruction_W` = 0, `valid_W` = 0), then the `sw` appears.
- **Timeout:** `TIMEOUT_CYCLES` = 4, `lw` with no ready → `stall_M` high for 4 cycles, then `mem_error` = 1 (sticky), `memData_W` = 0, `valid_W` = 1.
  - Subsequent ALU ops proceed normally; `mem_error` stays 1 until reset.
- **Ready/timeout tie:** ready arrives on the final allowed cycle → `mem_error` stays 0 and the data is captured.
- **Reset mid-WAIT:** assert reset during WAIT → `dmem_req`, `stall_M` and all W outputs are 0 immediately. After release, a `jal` with `pcPlus1_M` = 32'h21 gives `pcPlus1_W` = 32'h21 one cycle later.
